gpu_blitter: RTL and testbench
==============================

// Module: gpu_blitter
// PURPOSE
//  Second-generation sprite blitter. Copies a WxH rectangle from a spritesheet in memory into the
//  framebuffer at a signed (x,y), or clears the whole framebuffer to one colour. Sits between the
//  CPU-facing GPU control registers and the framebuffer write port. Supports memory with variable
//  read latency, clips against framebuffer bounds, and skips transparent pixels.
// PARAMETERS
//  FB_WIDTH   160  framebuffer width in pixels
//  FB_HEIGHT  120  framebuffer height in pixels
//  XW         8    fb_x width, >= clog2(FB_WIDTH)
//  YW         8    fb_y width, >= clog2(FB_HEIGHT)
// PORTS
//  clk              in   1   clock
//  rstn             in   1   asynchronous reset, active low
//  mem_rd           out  1   read request; one-cycle pulse, mem_addr valid in the same cycle
//  mem_addr         out  32  halfword address of the requested texel
//  mem_rvalid       in   1   read data valid; any latency >= 1 cycle after mem_rd
//  mem_rdata        in   16  texel; bit0 = opaque flag
//  ctrl_address     in   32  spritesheet base address
//  ctrl_address_x   in   16  source x offset in the sheet
//  ctrl_address_y   in   16  source y offset in the sheet
//  ctrl_sheetsize   in   16  sheet row pitch in texels
//  ctrl_width       in   16  rectangle width
//  ctrl_height      in   16  rectangle height
//  ctrl_x           in   16  destination left, signed two's complement
//  ctrl_y           in   16  destination top, signed
//  ctrl_draw        in   1   rising edge starts a draw
//  ctrl_clear_color in   16  clear colour
//  ctrl_clear       in   1   rising edge starts a clear
//  ctrl_flip_x      in   1   mirror source horizontally (GPU_FLIP_EN only)
//  ctrl_flip_y      in   1   mirror source vertically (GPU_FLIP_EN only)
//  ctrl_busy        out  1   high from the cycle after a command edge until the last pixel is done
//  fb_x             out  XW  destination x
//  fb_y             out  YW  destination y
//  fb_color         out  16  pixel colour
//  fb_write         out  1   write strobe; qualifies fb_x, fb_y and fb_color in the same cycle
// BEHAVIOUR
//  - Reset (async, rstn=0): all outputs 0, FSM IDLE, edge-detect registers 0. A mem_rvalid still in
//    flight when reset releases is ignored (WAIT is not active).
//  - Commands: ctrl_draw/ctrl_clear are edge-detected every cycle. An edge is accepted only in IDLE;
//    edges arriving while busy are dropped. If both edges occur in one cycle, clear wins.
//  - On acceptance, all ctrl_* inputs are latched; later changes have no effect until IDLE.
//  - FSM states: IDLE, SETUP, FETCH, WAIT, WRITE, CLEAR.
//    IDLE -> SETUP on an accepted draw; IDLE -> CLEAR on an accepted clear.
//    SETUP -> IDLE if width==0 or height==0 (ctrl_busy high for exactly 1 cycle); else -> FETCH.
//    FETCH: the current pixel is at px=x+col, py=y+row (17-bit signed).
//      If 0<=px<FB_WIDTH and 0<=py<FB_HEIGHT: assert mem_rd, go to WAIT.
//      Otherwise the pixel is clipped: no mem_rd; advance and stay in FETCH, or go to IDLE after the last pixel.
//    WAIT -> WRITE on mem_rvalid, capturing mem_rdata.
//    WRITE: fb_write=rdata[0], fb_x=px, fb_y=py, fb_color=rdata. Then advance; go to FETCH, or to IDLE after the last pixel.
//    CLEAR: one pixel per cycle in raster order, fb_write=1, fb_color=latched clear colour. The whole
//      clear takes FB_WIDTH*FB_HEIGHT cycles; no memory traffic. Then -> IDLE.
//  - Raster order: col 0..width-1 within a row, then row+1; the last pixel is (width-1, height-1).
//  - mem_addr = base + (addr_y+sy)*sheetsize + addr_x + sx, computed modulo 2^32.
//    sx=col and sy=row, except as changed by flips.
//  - fb_write, fb_x, fb_y and fb_color are registered. fb_write is 0 in every state other than WRITE and CLEAR.
//  - ctrl_busy = (state != IDLE).
//  - Draw throughput: latency L gives L+2 cycles per visible pixel and 1 cycle per clipped pixel.
// CONFIGURATION
//  GPU_FLIP_EN defined:
//    sx = flip_x ? width-1-col : col;  sy = flip_y ? height-1-row : row.
//    Flip bits are latched with the command. Destination order is unchanged.
//  GPU_FLIP_EN undefined:
//    ctrl_flip_x/ctrl_flip_y ports are still present but ignored; sx=col, sy=row.
// TESTING
//  1. Reset held, then released, with ctrl_* all 0:
//     all outputs 0; ctrl_busy=0.
//  2. Draw 2x2, x=y=0, base=0x100, pitch=16, address_x=y=0, memory latency 1, all texels opaque:
//     mem_addr sequence 0x100, 0x101, 0x110, 0x111; fb_write at (0,0), (1,0), (0,1), (1,1);
//     ctrl_busy falls 13 cycles after the edge.
//  3. Draw 4x1 at x=-2, y=0:
//     only 2 mem_rd; writes at fb_x=0 and fb_x=1 only. Same draw at y=FB_HEIGHT: zero mem_rd, zero writes.
//  4. Clear with colour 0xF801:
//     exactly 19200 fb_write pulses; the last one at (159,119) with fb_color=0xF801.
//     A second ctrl_draw edge mid-clear is dropped.
//  5. Draw with texel bit0=0, latency 5:
//     WAIT holds for 5 cycles; fb_write stays 0; ctrl_busy still deasserts after the last pixel.
//  6. Reset asserted mid-draw while in WAIT:
//     outputs go to 0 immediately; a late mem_rvalid produces no fb_write.
//     With GPU_FLIP_EN, flip_x on a 2x1 draw gives mem_addr order base+1, base.

Source files
------------

// File: rtl/gpu_blitter.sv
// ============================================================================
// Module   : gpu_blitter
// Brief    : Sprite blitter with clipping and transparency, plus framebuffer
//            clear. Optional source mirroring is enabled by GPU_FLIP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpu_blitter #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int XW        = 8,
    parameter int YW        = 8
) (
    input  logic          clk,
    input  logic          rstn,
    output logic          mem_rd,
    output logic [31:0]   mem_addr,
    input  logic          mem_rvalid,
    input  logic [15:0]   mem_rdata,
    input  logic [31:0]   ctrl_address,
    input  logic [15:0]   ctrl_address_x,
    input  logic [15:0]   ctrl_address_y,
    input  logic [15:0]   ctrl_sheetsize,
    input  logic [15:0]   ctrl_width,
    input  logic [15:0]   ctrl_height,
    input  logic [15:0]   ctrl_x,
    input  logic [15:0]   ctrl_y,
    input  logic          ctrl_draw,
    input  logic [15:0]   ctrl_clear_color,
    input  logic          ctrl_clear,
    input  logic          ctrl_flip_x,
    input  logic          ctrl_flip_y,
    output logic          ctrl_busy,
    output logic [XW-1:0] fb_x,
    output logic [YW-1:0] fb_y,
    output logic [15:0]   fb_color,
    output logic          fb_write
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_draw_d;
    logic          r_clear_d;
    logic [31:0]   r_base;
    logic [15:0]   r_ax;
    logic [15:0]   r_ay;
    logic [15:0]   r_pitch;
    logic [15:0]   r_w;
    logic [15:0]   r_h;
    logic [15:0]   r_x;
    logic [15:0]   r_y;
    logic [15:0]   r_col;
    logic [15:0]   r_row;
    logic          r_fb_write;
    logic [XW-1:0] r_fb_x;
    logic [YW-1:0] r_fb_y;
    logic [15:0]   r_fb_color;

    logic          w_draw_edge;
    logic          w_clear_edge;
    logic [16:0]   w_px;
    logic [16:0]   w_py;
    logic          w_visible;
    logic          w_col_last;
    logic          w_last;
    logic [15:0]   w_col_nxt;
    logic [15:0]   w_row_nxt;
    logic          w_clear_last;
    logic [15:0]   w_sx;
    logic [15:0]   w_sy;
    logic [31:0]   w_addr;

    assign w_draw_edge  = ctrl_draw & ~r_draw_d;
    assign w_clear_edge = ctrl_clear & ~r_clear_d;

    // Destination position is 17-bit signed so negative origins clip correctly.
    assign w_px = {r_x[15], r_x} + {1'b0, r_col};
    assign w_py = {r_y[15], r_y} + {1'b0, r_row};
    assign w_visible = !w_px[16] && (w_px < 17'(FB_WIDTH)) &&
                       !w_py[16] && (w_py < 17'(FB_HEIGHT));

    assign w_col_last = (r_col == r_w - 16'd1);
    assign w_last     = w_col_last && (r_row == r_h - 16'd1);
    assign w_col_nxt  = w_col_last ? 16'd0 : r_col + 16'd1;
    assign w_row_nxt  = w_col_last ? r_row + 16'd1 : r_row;

    assign w_clear_last = (r_fb_x == XW'(FB_WIDTH - 1)) && (r_fb_y == YW'(FB_HEIGHT - 1));

`ifdef GPU_FLIP_EN
    logic r_flip_x;
    logic r_flip_y;

    assign w_sx = r_flip_x ? (r_w - 16'd1 - r_col) : r_col;
    assign w_sy = r_flip_y ? (r_h - 16'd1 - r_row) : r_row;
`else
    logic w_unused_flip;

    assign w_unused_flip = ctrl_flip_x ^ ctrl_flip_y;
    assign w_sx = r_col;
    assign w_sy = r_row;
`endif

    assign w_addr = r_base
                  + ({16'd0, r_ay} + {16'd0, w_sy}) * {16'd0, r_pitch}
                  + {16'd0, r_ax} + {16'd0, w_sx};

    assign mem_rd    = (r_state == S_FETCH) && w_visible;
    assign mem_addr  = mem_rd ? w_addr : 32'd0;
    assign ctrl_busy = (r_state != S_IDLE);
    assign fb_write  = r_fb_write;
    assign fb_x      = r_fb_x;
    assign fb_y      = r_fb_y;
    assign fb_color  = r_fb_color;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_clear_edge) begin
                    w_next = S_CLEAR;
                end else if (w_draw_edge) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: w_next = (r_w == 16'd0 || r_h == 16'd0) ? S_IDLE : S_FETCH;
            S_FETCH: begin
                if (w_visible) begin
                    w_next = S_WAIT;
                end else if (w_last) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT:  if (mem_rvalid) w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_IDLE : S_FETCH;
            S_CLEAR: if (w_clear_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Framebuffer outputs are loaded on entry to WRITE/CLEAR so they are
    // registered yet still coincide with those states.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_draw_d   <= 1'b0;
            r_clear_d  <= 1'b0;
            r_base     <= 32'd0;
            r_ax       <= 16'd0;
            r_ay       <= 16'd0;
            r_pitch    <= 16'd0;
            r_w        <= 16'd0;
            r_h        <= 16'd0;
            r_x        <= 16'd0;
            r_y        <= 16'd0;
            r_col      <= 16'd0;
            r_row      <= 16'd0;
            r_fb_write <= 1'b0;
            r_fb_x     <= '0;
            r_fb_y     <= '0;
            r_fb_color <= 16'd0;
`ifdef GPU_FLIP_EN
            r_flip_x   <= 1'b0;
            r_flip_y   <= 1'b0;
`endif
        end else begin
            r_draw_d   <= ctrl_draw;
            r_clear_d  <= ctrl_clear;
            r_fb_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_clear_edge || w_draw_edge) begin
                        r_base  <= ctrl_address;
                        r_ax    <= ctrl_address_x;
                        r_ay    <= ctrl_address_y;
                        r_pitch <= ctrl_sheetsize;
                        r_w     <= ctrl_width;
                        r_h     <= ctrl_height;
                        r_x     <= ctrl_x;
                        r_y     <= ctrl_y;
                        r_col   <= 16'd0;
                        r_row   <= 16'd0;
`ifdef GPU_FLIP_EN
                        r_flip_x <= ctrl_flip_x;
                        r_flip_y <= ctrl_flip_y;
`endif
                    end
                    if (w_clear_edge) begin
                        r_fb_write <= 1'b1;
                        r_fb_x     <= '0;
                        r_fb_y     <= '0;
                        r_fb_color <= ctrl_clear_color;
                    end
                end
                S_FETCH: begin
                    if (!w_visible) begin
                        r_col <= w_col_nxt;
                        r_row <= w_row_nxt;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_fb_write <= mem_rdata[0];
                        r_fb_x     <= w_px[XW-1:0];
                        r_fb_y     <= w_py[YW-1:0];
                        r_fb_color <= mem_rdata;
                    end
                end
                S_WRITE: begin
                    r_col <= w_col_nxt;
                    r_row <= w_row_nxt;
                end
                S_CLEAR: begin
                    if (!w_clear_last) begin
                        r_fb_write <= 1'b1;
                        if (r_fb_x == XW'(FB_WIDTH - 1)) begin
                            r_fb_x <= '0;
                            r_fb_y <= r_fb_y + YW'(1);
                        end else begin
                            r_fb_x <= r_fb_x + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gpu_blitter.sv
// ============================================================================
// Module   : tb_gpu_blitter
// Brief    : Self-checking bench for gpu_blitter: directed table, random draws
//            against a pixel-level reference model, clear and reset sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gpu_blitter;

    localparam int FBW = 160;
    localparam int FBH = 120;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [31:0] ctrl_address;
    logic [15:0] ctrl_address_x, ctrl_address_y, ctrl_sheetsize;
    logic [15:0] ctrl_width, ctrl_height, ctrl_x, ctrl_y;
    logic        ctrl_draw, ctrl_clear, ctrl_flip_x, ctrl_flip_y;
    logic [15:0] ctrl_clear_color;
    logic        ctrl_busy;
    logic [7:0]  fb_x, fb_y;
    logic [15:0] fb_color;
    logic        fb_write;

    gpu_blitter #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .XW(8), .YW(8)) dut (
        .clk(clk), .rstn(rstn),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
        .ctrl_address_y(ctrl_address_y), .ctrl_sheetsize(ctrl_sheetsize),
        .ctrl_width(ctrl_width), .ctrl_height(ctrl_height), .ctrl_x(ctrl_x), .ctrl_y(ctrl_y),
        .ctrl_draw(ctrl_draw), .ctrl_clear_color(ctrl_clear_color), .ctrl_clear(ctrl_clear),
        .ctrl_flip_x(ctrl_flip_x), .ctrl_flip_y(ctrl_flip_y), .ctrl_busy(ctrl_busy),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [15:0] ax, ay, pitch, w, h, x, y;
        int          lat;
        int          mode;   // 0 all opaque, 1 all transparent, 2 per-texel
        bit          fx, fy;
        int          e_rd, e_wr, e_busy;   // -1 means "model only"
    } vec_t;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cur_lat = 1;
    int cur_mode = 0;
    int unsigned cyc = 0;

    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    int          exp_busy;

    bit          pend_v = 1'b0;
    int unsigned pend_due;
    logic [31:0] pend_addr;

    function automatic logic [15:0] texel(input logic [31:0] a, input int mode);
        logic [15:0] t;
        t = a[15:0] ^ a[31:16] ^ 16'hA55A ^ {a[7:0], a[15:8]};
        if (mode == 0) t[0] = 1'b1;
        else if (mode == 1) t[0] = 1'b0;
        return t;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with fixed per-command latency; rvalid is a one-cycle pulse.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (pend_v && cyc == pend_due) begin
            mem_rvalid = 1'b1;
            mem_rdata  = texel(pend_addr, cur_mode);
            pend_v     = 1'b0;
        end
        if (mem_rd) begin
            pend_v    = 1'b1;
            pend_due  = cyc + cur_lat;
            pend_addr = mem_addr;
        end
    end

    always @(negedge clk) begin
        if (mem_rd)   rd_q.push_back(mem_addr);
        if (fb_write) wr_q.push_back({fb_x, fb_y, fb_color});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] x, y, w, h, input logic [31:0] base,
                                input logic [15:0] pitch, input int lat, mode, input bit fx,
                                input int e_rd, e_wr, e_busy);
        vec_t v;
        v.x = x; v.y = y; v.w = w; v.h = h; v.base = base; v.pitch = pitch;
        v.ax = 16'd0; v.ay = 16'd0; v.lat = lat; v.mode = mode; v.fx = fx; v.fy = 1'b0;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_busy = e_busy;
        return v;
    endfunction

    // Reference: walk the rectangle in raster order, clip, look up texels.
    task automatic build_model(input vec_t c);
        int px, py, sx, sy;
        logic [31:0] a;
        logic [15:0] t;
        exp_rd.delete();
        exp_wr.delete();
        exp_busy = 1;
        for (int row = 0; row < int'(c.h); row++) begin
            for (int col = 0; col < int'(c.w); col++) begin
                px = $signed(c.x) + col;
                py = $signed(c.y) + row;
                if (px >= 0 && px < FBW && py >= 0 && py < FBH) begin
                    sx = col;
                    sy = row;
`ifdef GPU_FLIP_EN
                    if (c.fx) sx = int'(c.w) - 1 - col;
                    if (c.fy) sy = int'(c.h) - 1 - row;
`endif
                    a = c.base + (32'(c.ay) + 32'(sy)) * 32'(c.pitch) + 32'(c.ax) + 32'(sx);
                    t = texel(a, c.mode);
                    exp_rd.push_back(a);
                    if (t[0]) exp_wr.push_back({8'(px), 8'(py), t});
                    exp_busy += c.lat + 2;
                end else begin
                    exp_busy += 1;
                end
            end
        end
    endtask

    task automatic run_draw(input vec_t c);
        int bc;
        build_model(c);
        @(negedge clk);
        rd_q.delete();
        wr_q.delete();
        cur_lat = c.lat;
        cur_mode = c.mode;
        ctrl_address = c.base; ctrl_address_x = c.ax; ctrl_address_y = c.ay;
        ctrl_sheetsize = c.pitch; ctrl_width = c.w; ctrl_height = c.h;
        ctrl_x = c.x; ctrl_y = c.y; ctrl_flip_x = c.fx; ctrl_flip_y = c.fy;
        ctrl_draw = 1'b1;
        @(negedge clk);
        ctrl_draw = 1'b0;
        // Inputs change after acceptance; the latched command must be used.
        ctrl_address = $urandom; ctrl_address_x = 16'($urandom); ctrl_address_y = 16'($urandom);
        ctrl_sheetsize = 16'($urandom); ctrl_width = 16'($urandom); ctrl_height = 16'($urandom);
        ctrl_x = 16'($urandom); ctrl_y = 16'($urandom);
        ctrl_flip_x = ~c.fx; ctrl_flip_y = ~c.fy;
        bc = 0;
        while (ctrl_busy && bc < 5000) begin
            bc++;
            @(negedge clk);
        end
        chk("draw_busy", 64'(bc), 64'(exp_busy));
        chk("draw_nrd", 64'(rd_q.size()), 64'(exp_rd.size()));
        chk("draw_nwr", 64'(wr_q.size()), 64'(exp_wr.size()));
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) chk("draw_addr", 64'(rd_q[i]), 64'(exp_rd[i]));
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) chk("draw_pix", 64'(wr_q[i]), 64'(exp_wr[i]));
        if (c.e_busy >= 0) chk("tbl_busy", 64'(bc), 64'(c.e_busy));
        if (c.e_rd >= 0)   chk("tbl_nrd", 64'(rd_q.size()), 64'(c.e_rd));
        if (c.e_wr >= 0)   chk("tbl_nwr", 64'(wr_q.size()), 64'(c.e_wr));
    endtask

    task automatic run_clear(input logic [15:0] color, input bit with_draw, input bit mid_draw);
        int bc, nbad;
        @(negedge clk);
        rd_q.delete();
        wr_q.delete();
        cur_lat = 1; cur_mode = 0;
        ctrl_address = 32'h40; ctrl_address_x = 0; ctrl_address_y = 0; ctrl_sheetsize = 8;
        ctrl_width = 2; ctrl_height = 2; ctrl_x = 0; ctrl_y = 0;
        ctrl_clear_color = color;
        ctrl_clear = 1'b1;
        ctrl_draw = with_draw;
        @(negedge clk);
        ctrl_clear = 1'b0;
        ctrl_draw = 1'b0;
        ctrl_clear_color = ~color;
        bc = 0;
        while (ctrl_busy && bc < 25000) begin
            bc++;
            if (mid_draw && bc == 100) ctrl_draw = 1'b1;
            if (bc == 102) ctrl_draw = 1'b0;
            @(negedge clk);
        end
        chk("clear_busy", 64'(bc), 64'(FBW * FBH));
        chk("clear_nwr", 64'(wr_q.size()), 64'(FBW * FBH));
        chk("clear_nrd", 64'(rd_q.size()), 64'd0);
        nbad = 0;
        for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i] !== {8'(i % FBW), 8'(i / FBW), color}) nbad++;
        chk("clear_order", 64'(nbad), 64'd0);
        if (wr_q.size() > 0) chk("clear_last", 64'(wr_q[wr_q.size()-1]), 64'({8'd159, 8'd119, color}));
        repeat (20) @(negedge clk);
        chk("clear_drop_busy", 64'(ctrl_busy), 64'd0);
        chk("clear_drop_wr", 64'(wr_q.size()), 64'(FBW * FBH));
        chk("clear_drop_rd", 64'(rd_q.size()), 64'd0);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        int g;
        rstn = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 16'd0;
        ctrl_address = 0; ctrl_address_x = 0; ctrl_address_y = 0; ctrl_sheetsize = 0;
        ctrl_width = 0; ctrl_height = 0; ctrl_x = 0; ctrl_y = 0;
        ctrl_draw = 0; ctrl_clear = 0; ctrl_flip_x = 0; ctrl_flip_y = 0; ctrl_clear_color = 0;

        tbl[0] = mk(16'd0,     16'd0,   16'd2, 16'd2, 32'h100,  16'd16, 1, 0, 1'b0, 4, 4, 13);
        tbl[1] = mk(-16'sd2,   16'd0,   16'd4, 16'd1, 32'h200,  16'd16, 1, 0, 1'b0, 2, 2, 9);
        tbl[2] = mk(-16'sd2,   16'd120, 16'd4, 16'd1, 32'h200,  16'd16, 1, 0, 1'b0, 0, 0, 5);
        tbl[3] = mk(16'd3,     16'd3,   16'd0, 16'd3, 32'h300,  16'd16, 1, 0, 1'b0, 0, 0, 1);
        tbl[4] = mk(16'd10,    16'd10,  16'd3, 16'd2, 32'h400,  16'd32, 5, 1, 1'b0, 6, 0, 43);
        tbl[5] = mk(16'd159,   16'd119, 16'd2, 16'd2, 32'h500,  16'd16, 2, 0, 1'b0, 1, 1, 8);
        tbl[6] = mk(16'd7,     16'd7,   16'd5, 16'd0, 32'h600,  16'd16, 1, 0, 1'b0, 0, 0, 1);
        tbl[7] = mk(16'd5,     16'd5,   16'd2, 16'd1, 32'h2000, 16'd8,  3, 0, 1'b1, 2, 2, 11);

        repeat (3) @(negedge clk);
        chk("rst_mem", 64'({mem_rd, mem_addr}), 64'd0);
        chk("rst_fb", 64'({ctrl_busy, fb_write, fb_x, fb_y, fb_color}), 64'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_mem", 64'({mem_rd, mem_addr}), 64'd0);
        chk("post_rst_fb", 64'({ctrl_busy, fb_write, fb_x, fb_y, fb_color}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_draw(tbl[i]);
`ifdef GPU_FLIP_EN
            if (tbl[i].fx) chk("flip_first_addr", 64'(rd_q[0]), 64'(tbl[i].base + 32'd1));
`endif
        end

        for (int n = 0; n < 40; n++) begin
            rv.base = $urandom; rv.ax = 16'($urandom); rv.ay = 16'($urandom);
            rv.pitch = 16'($urandom);
            rv.w = 16'($urandom_range(0, 6)); rv.h = 16'($urandom_range(0, 5));
            rv.x = 16'(int'($urandom_range(0, 172)) - 8);
            rv.y = 16'(int'($urandom_range(0, 132)) - 8);
            rv.lat = $urandom_range(1, 4); rv.mode = $urandom_range(0, 2);
            rv.fx = 1'($urandom); rv.fy = 1'($urandom);
            rv.e_rd = -1; rv.e_wr = -1; rv.e_busy = -1;
            run_draw(rv);
        end

        run_clear(16'hF801, 1'b0, 1'b1);
        run_clear(16'h07E0, 1'b1, 1'b0);

        // Reset while a read is outstanding; the late rvalid must be ignored.
        @(negedge clk);
        rd_q.delete();
        wr_q.delete();
        cur_lat = 6; cur_mode = 0;
        ctrl_address = 32'h900; ctrl_address_x = 0; ctrl_address_y = 0; ctrl_sheetsize = 16;
        ctrl_width = 2; ctrl_height = 2; ctrl_x = 4; ctrl_y = 4;
        ctrl_flip_x = 0; ctrl_flip_y = 0;
        ctrl_draw = 1'b1;
        g = 0;
        while (rd_q.size() == 0 && g < 30) begin
            g++;
            @(negedge clk);
        end
        ctrl_draw = 1'b0;
        chk("rstw_rd_seen", 64'(rd_q.size()), 64'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rstw_mem", 64'({mem_rd, mem_addr}), 64'd0);
        chk("rstw_fb", 64'({ctrl_busy, fb_write, fb_x, fb_y, fb_color}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        wr_q.delete();
        repeat (12) @(negedge clk);
        chk("rstw_no_wr", 64'(wr_q.size()), 64'd0);
        chk("rstw_idle", 64'(ctrl_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
